// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue/writeback controller driving a combinational ALU
module alu_issue #(
   parameter int NREGS = 8,
   parameter int IMMW  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic [31:0] alu_in0,
   output logic [31:0] alu_in1,
   output logic [2:0]  alu_sel,
   input  logic [31:0] alu_out,
   input  logic        alu_zero,
   output logic        wb_valid,
   output logic [2:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        zero_flag,
   input  logic [2:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_accept;
   logic        w_imm_flag;
   logic [2:0]  w_op;
   logic [2:0]  w_rd;
   logic [2:0]  w_rs1;
   logic [2:0]  w_rs2;
   logic [31:0] w_imm_sx;
   logic        w_unused;

   logic [31:0] r_regs [NREGS];
   logic [31:0] r_alu_in0;
   logic [31:0] r_alu_in1;
   logic [2:0]  r_alu_sel;
   logic [2:0]  r_rd;
   logic [2:0]  r_wb_rd;
   logic [31:0] r_wb_data;
   logic        r_zres;
   logic        r_zero_flag;

   assign w_imm_flag = instr[31];
   assign w_op       = instr[30:28];
   assign w_rd       = instr[27:25];
   assign w_rs1      = instr[24:22];
   assign w_rs2      = instr[21:19];
   assign w_imm_sx   = {{(32-IMMW){instr[IMMW-1]}}, instr[IMMW-1:0]};
   assign w_unused   = ^instr[18:16];

   // State register; reset drops any in-flight instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode and handshake/strobe outputs
   always_comb begin
      w_next      = r_state;
      instr_ready = 1'b0;
      wb_valid    = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            instr_ready = ~rst;
            w_accept    = instr_valid & ~rst;
            if (w_accept) w_next = S_EXEC;
         end
         S_EXEC: w_next = S_WB;
         S_WB: begin
            wb_valid = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operand capture at accept; registers cannot change before EXEC, so these
   // equal the live register contents while EXEC is active and hold afterwards
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_in0 <= '0;
         r_alu_in1 <= '0;
         r_alu_sel <= '0;
         r_rd      <= '0;
      end else if (w_accept) begin
         r_alu_in0 <= r_regs[w_rs1];
         r_alu_in1 <= w_imm_flag ? w_imm_sx : r_regs[w_rs2];
         r_alu_sel <= w_op;
         r_rd      <= w_rd;
      end
   end

   // Result capture at the end of EXEC; wb_rd/wb_data hold between strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_rd   <= '0;
         r_wb_data <= '0;
         r_zres    <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_wb_rd   <= r_rd;
         r_wb_data <= alu_out;
         r_zres    <= alu_zero;
      end
   end

   // Register file and zero flag retire at the end of WB; r0 is never written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_zero_flag <= 1'b0;
      end else if (r_state == S_WB) begin
         if (r_wb_rd != 3'd0) r_regs[r_wb_rd] <= r_wb_data;
         r_zero_flag <= r_zres;
      end
   end

   assign alu_in0   = r_alu_in0;
   assign alu_in1   = r_alu_in1;
   assign alu_sel   = r_alu_sel;
   assign wb_rd     = r_wb_rd;
   assign wb_data   = r_wb_data;
   assign zero_flag = r_zero_flag;
   assign dbg_data  = (dbg_addr == 3'd0) ? 32'd0 : r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue
`timescale 1ns/1ps
module tb_alu_issue;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] alu_in0;
   logic [31:0] alu_in1;
   logic [2:0]  alu_sel;
   logic [31:0] alu_out;
   logic        alu_zero;
   logic        wb_valid;
   logic [2:0]  wb_rd;
   logic [31:0] wb_data;
   logic        zero_flag;
   logic [2:0]  dbg_addr;
   logic [31:0] dbg_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [34:0] sb_q [$];

   alu_issue #(.NREGS(8), .IMMW(16)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .zero_flag(zero_flag),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment ALU: the combinational block the controller drives
   always_comb begin
      case (alu_sel)
         3'd0:    alu_out = alu_in0 + alu_in1;
         3'd1:    alu_out = alu_in0 - alu_in1;
         3'd2:    alu_out = alu_in0 & alu_in1;
         3'd3:    alu_out = alu_in0 | alu_in1;
         3'd4:    alu_out = alu_in0 ^ alu_in1;
         3'd5:    alu_out = alu_in0 << alu_in1[5:0];
         3'd6:    alu_out = alu_in0 >> alu_in1[5:0];
         default: alu_out = $unsigned($signed(alu_in0) >>> alu_in1[5:0]);
      endcase
      alu_zero = (alu_out == 32'd0);
   end

   // Scoreboard consumer: every writeback strobe must match a queued expectation
   always @(negedge clk) begin
      if (!rst && wb_valid) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", wb_rd, wb_data);
         end else begin
            logic [34:0] e;
            e = sb_q.pop_front();
            if ({wb_rd, wb_data} !== e) begin
               n_fail++;
               $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                        wb_rd, wb_data, e[34:32], e[31:0]);
            end
         end
      end
   end

   task automatic check_dbg(input logic [2:0] a, input logic [31:0] exp, input string nm);
      dbg_addr = a;
      #1;
      n_tests++;
      if (dbg_data !== exp) begin
         n_fail++;
         $display("FAIL %s: dbg r%0d got %h, required %h", nm, a, dbg_data, exp);
      end
   endtask

   task automatic check_bit(input logic got, input logic exp, input string nm);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", nm, got, exp);
      end
   endtask

   // Issue one instruction from IDLE and follow it through EXEC and WB
   task automatic issue(input logic [31:0] ins, input logic [2:0] exp_rd,
                        input logic [31:0] exp_data, output logic [2:0] sel_in_exec);
      @(negedge clk);
      check_bit(instr_ready, 1'b1, "issue_ready");
      instr       = ins;
      instr_valid = 1'b1;
      sb_q.push_back({exp_rd, exp_data});
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 32'hDEAD_BEEF;
      sel_in_exec = alu_sel;
      check_bit(wb_valid, 1'b0, "latency_exec_no_wb");
      check_bit(instr_ready, 1'b0, "exec_not_ready");
      @(negedge clk);
      check_bit(wb_valid, 1'b1, "latency_wb_at_2");
      @(negedge clk);
      check_bit(wb_valid, 1'b0, "wb_one_cycle");
      check_bit(instr_ready, 1'b1, "ready_after_wb");
   endtask

   task automatic test_reset();
      logic [2:0] a;
      rst = 1'b1;
      instr_valid = 1'b0;
      instr = '0;
      dbg_addr = '0;
      repeat (2) @(negedge clk);
      check_bit(instr_ready, 1'b0, "reset_ready_low");
      n_tests++;
      if ({alu_in0, alu_in1, alu_sel} !== 67'd0) begin
         n_fail++;
         $display("FAIL reset_alu_inputs: got %h %h %h, required 0", alu_in0, alu_in1, alu_sel);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_bit(instr_ready, 1'b1, "idle_ready");
      check_bit(wb_valid, 1'b0, "idle_wb_valid");
      check_bit(zero_flag, 1'b0, "idle_zero_flag");
      for (int i = 0; i < 8; i++) begin
         a = i[2:0];
         check_dbg(a, 32'd0, "reset_regs");
      end
   endtask

   task automatic test_addi();
      logic [2:0] s;
      issue(32'h8200_0005, 3'd1, 32'd5, s);
      check_dbg(3'd1, 32'd5, "addi_r1");
      check_bit(zero_flag, 1'b0, "addi_zero_flag");
   endtask

   task automatic test_sub_zero();
      logic [2:0] s;
      issue(32'h1448_0000, 3'd2, 32'd0, s);
      n_tests++;
      if (s !== 3'd1) begin
         n_fail++;
         $display("FAIL sub_alu_sel: got %0d, required 1", s);
      end
      check_bit(zero_flag, 1'b1, "sub_zero_flag_set");
      issue(32'h8200_0005, 3'd1, 32'd5, s);
      check_bit(zero_flag, 1'b0, "zero_flag_cleared");
   endtask

   task automatic test_sari();
      logic [2:0] s;
      issue(32'h8800_FFF0, 3'd4, 32'hFFFF_FFF0, s);
      issue(32'hF700_0002, 3'd3, 32'hFFFF_FFFC, s);
      n_tests++;
      if (s !== 3'd7) begin
         n_fail++;
         $display("FAIL sar_alu_sel: got %0d, required 7", s);
      end
      check_dbg(3'd4, 32'hFFFF_FFF0, "addi_neg_r4");
      check_dbg(3'd3, 32'hFFFF_FFFC, "sari_r3");
   endtask

   task automatic test_r0();
      logic [2:0] s;
      issue(32'h8000_0007, 3'd0, 32'd7, s);
      check_dbg(3'd0, 32'd0, "r0_hardwired");
   endtask

   task automatic test_back_to_back();
      logic [8:0] pat;
      int accepts;
      accepts = 0;
      @(negedge clk);
      instr       = 32'h8B40_0001;
      instr_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         pat[i] = instr_ready;
         if (instr_ready) begin
            accepts++;
            sb_q.push_back({3'd5, 32'(accepts)});
         end
         @(negedge clk);
      end
      instr_valid = 1'b0;
      n_tests++;
      if (accepts != 3) begin
         n_fail++;
         $display("FAIL b2b_accepts: got %0d, required 3", accepts);
      end
      n_tests++;
      if (pat !== 9'b001_001_001) begin
         n_fail++;
         $display("FAIL b2b_ready_pattern: got %b, required %b", pat, 9'b001_001_001);
      end
      @(negedge clk);
      check_dbg(3'd5, 32'd3, "b2b_r5");
   endtask

   task automatic test_reset_exec();
      logic [2:0] a;
      @(negedge clk);
      instr       = 32'h8C00_0033;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_bit(instr_ready, 1'b0, "rst_exec_ready_low");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_bit(instr_ready, 1'b1, "ready_after_release");
      check_bit(wb_valid, 1'b0, "rst_exec_no_wb");
      repeat (2) @(negedge clk);
      check_bit(zero_flag, 1'b0, "rst_exec_zero_flag");
      for (int i = 0; i < 8; i++) begin
         a = i[2:0];
         check_dbg(a, 32'd0, "rst_exec_regs");
      end
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_sub_zero();
      test_sari();
      test_r0();
      test_back_to_back();
      test_reset_exec();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Sequential issue/writeback controller that drives the combinational `alu` as its initiator. It accepts 32-bit instruction words over a valid/ready handshake and decodes them into the ALU's `in0`/`in1`/`selector` inputs. It captures `out0`/`zero` and writes the result back into a private 8×32 register file, which forms the execute stage of the team's minimal datapath.

## Interface
Parameters:
- `NREGS`, 8: register count; index width fixed at 3 bits, so only 8 is legal.
- `IMMW`, 16: immediate width; sign-extended to 32.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `instr_valid` input 1: instruction word present.
- `instr_ready` output 1: controller can accept; high only in IDLE.
- `instr` input 32: instruction word (format below).
- `alu_in0` output 32: to `alu.in0`.
- `alu_in1` output 32: to `alu.in1`.
- `alu_sel` output 3: to `alu.selector`.
- `alu_out` input 32: from `alu.out0`.
- `alu_zero` input 1: from `alu.zero`.
- `wb_valid` output 1: one-cycle writeback strobe.
- `wb_rd` output 3: writeback destination.
- `wb_data` output 32: writeback value.
- `zero_flag` output 1: sticky copy of `alu_zero` from the last retired instruction.
- `dbg_addr` input 3: debug register read address.
- `dbg_data` output 32: combinational read of `reg[dbg_addr]`; `r0` always reads 0.

## Operation
Instruction fields:
- `[31]` imm flag.
- `[30:28]` op, placed directly on `alu_sel`.
- `[27:25]` rd.
- `[24:22]` rs1.
- `[21:19]` rs2.
- `[15:0]` imm.
- Bits `[18:16]` are ignored.

Selector codes (shared ALU header): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SLR=6, SAR=7.

Operand selection:
- `alu_in0` = `reg[rs1]`.
- `alu_in1` = imm flag ? sign-extend(imm) : `reg[rs2]`.
- Shift count is whatever the ALU takes from `alu_in1[5:0]`; no clamping here.

Register `r0` is hardwired zero: writes to it are discarded, but `wb_valid` still pulses with the computed `wb_data`.

FSM, three states, one-hot or binary:
- **IDLE**: `instr_ready`=1. On `instr_valid & instr_ready`, latch `instr` and go to EXEC.
- **EXEC**: ALU inputs driven from latched fields and current register contents. At the clock edge, capture `alu_out` → `res`, capture `alu_zero` → `zres`, go to WB.
- **WB**: `wb_valid`=1, `wb_rd`=latched rd, `wb_data`=`res`. At the clock edge, write `reg[rd]`=`res` if rd≠0, set `zero_flag`=`zres`, go to IDLE.

Outputs outside the stated states:
- `alu_in0`, `alu_in1`, and `alu_sel` hold the last latched instruction's values outside EXEC. They are 0 after reset.
- `wb_rd` and `wb_data` hold their values when `wb_valid`=0.

## Timing
- Accept at edge T0; EXEC during cycle T0–T1; WB during T1–T2 with `wb_valid` high; register file and `zero_flag` updated at T2; `instr_ready` high from T2.
- Latency is 2 cycles from accept to `wb_valid`. Maximum throughput is one instruction per 3 cycles.
- No hazards: the next instruction is accepted at or after T2, so it reads updated registers.
- `instr` and `instr_valid` are ignored outside IDLE. The source must hold `instr` stable while `instr_valid` is high and `instr_ready` is low.
- Reset values, all asynchronous:
  - State = IDLE.
  - All registers = 0.
  - `wb_valid`, `wb_rd`, `wb_data`, and `zero_flag` = 0.
  - `alu_in0`, `alu_in1`, and `alu_sel` = 0.
  - `instr_ready` = 0 while `rst` is high, 1 in the first cycle after release.
- Reset during EXEC or WB: the in-flight instruction is dropped. There is no `wb_valid` and no register write, and the register file is cleared.

## Test plan
1. Reset, then idle 3 cycles → `instr_ready`=1, `wb_valid`=0, `zero_flag`=0, `dbg_data`=0 for every `dbg_addr`.
2. `0x82000005` (ADDI r1=r0+5) → `wb_valid` exactly 2 cycles after accept with `wb_rd`=1, `wb_data`=5; `dbg r1`=5, `zero_flag`=0.
3. Then `0x14480000` (SUB r2=r1−r1) → `alu_sel`=1 in EXEC, `wb_data`=0, `zero_flag`=1 after WB; then re-run step 2 and expect `zero_flag` to return to 0.
4. `0x8800FFF0` (ADDI r4=−16), then `0xF7000002` (SARI r3=r4>>2) → `dbg r4`=`0xFFFFFFF0`, `dbg r3`=`0xFFFFFFFC`.
5. `0x80000007` (ADDI r0=7) → `wb_valid` pulses with `wb_data`=7; `dbg r0` remains 0.
6. Hold `instr_valid`=1 for 9 cycles → exactly 3 accepts, `instr_ready` pattern 1,0,0 repeating. Separately, assert `rst` during EXEC → no `wb_valid`, all registers 0, `instr_ready`=1 one cycle after release.
